// File: rtl/writeback_display_sequencer.sv
// Paces Data_Buffer writeback words onto the seven-segment display: pop, load, then hold each
// word for a fixed number of cycles. Optional fast-drain is enabled with `define WB_FASTDRAIN_EN.
module writeback_display_sequencer #(
    parameter int DATA_W      = 32,
    parameter int OCC_W       = 6,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int HIGH_WATER  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OCC_W-1:0]  buf_occ,
    input  logic [DATA_W-1:0] buf_data,
    output logic              buf_pop,
    input  logic              freeze,
    input  logic              skip,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [15:0]       shown_count
);

    localparam int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int FAST_CYCLES = ((HOLD_CYCLES >> 2) < 1) ? 1 : (HOLD_CYCLES >> 2);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_CYCLES - 1);

`ifdef WB_FASTDRAIN_EN
    localparam bit FASTDRAIN_ON = 1'b1;
`else
    localparam bit FASTDRAIN_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        POP,
        LOAD,
        SHOW
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_last;
    logic             high_water_hit;
    logic             buf_nonempty;

    assign buf_nonempty   = (buf_occ != '0);
    assign high_water_hit = (int'(buf_occ) >= HIGH_WATER);

    // The pop strobe is a pure decode of the registered state.
    assign buf_pop = (state == POP);

    // Terminal count is latched per word so a mid-hold occupancy change cannot stretch or cut it.
    function automatic logic [CNT_W-1:0] select_last(input logic hit);
        return (FASTDRAIN_ON && hit) ? FAST_LAST : FULL_LAST;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            disp_data   <= '0;
            disp_valid  <= 1'b0;
            shown_count <= '0;
            hold_cnt    <= '0;
            hold_last   <= FULL_LAST;
        end else begin
            case (state)
                IDLE: begin
                    if (buf_nonempty && !freeze)
                        state <= POP;
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    disp_data   <= buf_data;
                    disp_valid  <= 1'b1;
                    shown_count <= shown_count + 16'd1;
                    hold_cnt    <= '0;
                    hold_last   <= select_last(high_water_hit);
                    state       <= SHOW;
                end
                SHOW: begin
                    // Freeze stalls the hold entirely; a skip arriving while frozen is dropped.
                    if (!freeze) begin
                        if (skip || (hold_cnt == hold_last))
                            state <= buf_nonempty ? POP : IDLE;
                        else
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
